// File: rtl/apb_loader_pkg.sv
// Shared types and constants for the APB image loader.
package apb_loader_pkg;

  localparam int unsigned START_ADDR  = 0;
  localparam int unsigned ITERATION   = 4096;
  localparam int unsigned PIXEL_WIDTH = 8;

  typedef enum logic [3:0] {
    StIdle,
    StWaitPx,
    StWSetup,
    StWAccess,
    StRSetup,
    StRAccess,
    StSSetup,
    StSAccess,
    StWaitDone,
    StCSetup,
    StCAccess,
    StReport
  } loader_state_e;

  typedef enum logic [1:0] {
    PhIdle,
    PhSetup,
    PhAccess
  } phase_e;

endpackage

// File: rtl/apb_master_phase.sv
// Two-cycle APB SETUP/ACCESS sequencer; a request latches address, data and direction.
module apb_master_phase
  import apb_loader_pkg::*;
#(
  parameter int unsigned AddrW = 13,
  parameter int unsigned DataW = 24
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_i,
  input  logic             write_i,
  input  logic [AddrW-1:0] addr_i,
  input  logic [DataW-1:0] data_i,
  output logic             done_o,
  output logic             psel_o,
  output logic             penable_o,
  output logic             pwrite_o,
  output logic [AddrW-1:0] paddr_o,
  output logic [DataW-1:0] pwdata_o
);

  phase_e             phase_q, phase_d;
  logic               pwrite_q;
  logic [AddrW-1:0]   paddr_q;
  logic [DataW-1:0]   pwdata_q;

  // A request during ACCESS chains straight into the next SETUP.
  always_comb begin
    phase_d = PhIdle;
    unique case (phase_q)
      PhSetup: phase_d = PhAccess;
      default: phase_d = req_i ? PhSetup : PhIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      phase_q  <= PhIdle;
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
    end else begin
      phase_q <= phase_d;
      if (phase_d == PhSetup) begin
        pwrite_q <= write_i;
        paddr_q  <= addr_i;
        pwdata_q <= data_i;
      end
    end
  end

  assign psel_o    = (phase_q != PhIdle);
  assign penable_o = (phase_q == PhAccess);
  assign done_o    = (phase_q == PhAccess);
  assign pwrite_o  = pwrite_q;
  assign paddr_o   = paddr_q;
  assign pwdata_o  = pwdata_q;

endmodule

// File: rtl/apb_image_loader.sv
// APB initiator loading an image into the CatRecognizer and reporting its verdict.
// Define READBACK_VERIFY_EN to read back every pixel word and flag mismatches on err.
module apb_image_loader #(
  parameter int unsigned AMBA_WORD       = 24,
  parameter int unsigned AMBA_ADDR_DEPTH = 12,
  parameter int unsigned PIXEL_WIDTH     = apb_loader_pkg::PIXEL_WIDTH,
  parameter int unsigned ITERATION       = apb_loader_pkg::ITERATION,
  parameter int unsigned START_ADDR      = apb_loader_pkg::START_ADDR
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     px_valid,
  input  logic [AMBA_WORD-1:0]     px_data,
  output logic                     px_ready,
  output logic                     PSEL,
  output logic                     PENABLE,
  output logic                     PWRITE,
  output logic [AMBA_ADDR_DEPTH:0] PADDR,
  output logic [AMBA_WORD-1:0]     PWDATA,
  input  logic [AMBA_WORD-1:0]     PRDATA,
  input  logic                     CatRecOut,
  input  logic                     done_flag,
  output logic                     busy,
  output logic                     result_valid,
  output logic                     cat_result,
  output logic                     err
);
  import apb_loader_pkg::*;

  localparam int unsigned      AddrW     = AMBA_ADDR_DEPTH + 1;
  localparam logic [AddrW-1:0] LastAddr  = AddrW'(ITERATION);
  localparam logic [AddrW-1:0] StartAddr = AddrW'(START_ADDR);

  loader_state_e          state_q, state_d;
  logic [AddrW-1:0]       cnt_q, cnt_d;
  logic [AMBA_WORD-1:0]   word_q, word_d;
  logic                   cat_q, cat_d;

  logic                   req, req_write, ph_done;
  logic [AddrW-1:0]       req_addr;
  logic [AMBA_WORD-1:0]   req_data;

  logic [PIXEL_WIDTH-1:0] unused_p1;
  assign unused_p1 = px_data[PIXEL_WIDTH-1:0];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    word_d    = word_q;
    cat_d     = cat_q;
    req       = 1'b0;
    req_write = 1'b1;
    req_addr  = cnt_q;
    req_data  = word_q;
    unique case (state_q)
      StIdle:   if (start) state_d = StWaitPx;
      StWaitPx: begin
        if (px_valid) begin
          word_d   = px_data;
          req      = 1'b1;
          req_data = px_data;
          state_d  = StWSetup;
        end
      end
      StWSetup: state_d = StWAccess;
`ifdef READBACK_VERIFY_EN
      StWAccess: begin
        if (ph_done) begin
          req       = 1'b1;
          req_write = 1'b0;
          state_d   = StRSetup;
        end
      end
      StRSetup: state_d = StRAccess;
      StRAccess: begin
`else
      StWAccess: begin
`endif
        // Last word chains directly into the start-register write.
        if (ph_done) begin
          if (cnt_q == LastAddr) begin
            req      = 1'b1;
            req_addr = StartAddr;
            req_data = AMBA_WORD'(1);
            state_d  = StSSetup;
          end else begin
            cnt_d   = cnt_q + AddrW'(1);
            state_d = StWaitPx;
          end
        end
      end
      StSSetup:  state_d = StSAccess;
      StSAccess: if (ph_done) state_d = StWaitDone;
      StWaitDone: begin
        if (done_flag) begin
          cat_d    = CatRecOut;
          req      = 1'b1;
          req_addr = StartAddr;
          req_data = '0;
          state_d  = StCSetup;
        end
      end
      StCSetup:  state_d = StCAccess;
      StCAccess: if (ph_done) state_d = StReport;
      StReport: begin
        cnt_d   = AddrW'(1);
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= AddrW'(1);
      word_q  <= '0;
      cat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      cat_q   <= cat_d;
    end
  end

`ifdef READBACK_VERIFY_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (state_q == StRAccess && PRDATA != word_q) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) err_q <= 1'b0;
    else      err_q <= err_d;
  end

  assign err = err_q;
`else
  logic unused_prdata;
  assign unused_prdata = ^PRDATA;
  assign err           = 1'b0;
`endif

  apb_master_phase #(
    .AddrW (AddrW),
    .DataW (AMBA_WORD)
  ) u_phase (
    .clk_i     (clk),
    .rst_ni    (rst),
    .req_i     (req),
    .write_i   (req_write),
    .addr_i    (req_addr),
    .data_i    (req_data),
    .done_o    (ph_done),
    .psel_o    (PSEL),
    .penable_o (PENABLE),
    .pwrite_o  (PWRITE),
    .paddr_o   (PADDR),
    .pwdata_o  (PWDATA)
  );

  assign px_ready     = (state_q == StWaitPx);
  assign busy         = (state_q != StIdle);
  assign result_valid = (state_q == StReport);
  assign cat_result   = cat_q;

endmodule

// File: tb/tb_apb_image_loader.sv
// Self-checking bench for apb_image_loader with a four-word image.
module tb_apb_image_loader;
  localparam int NW = 4;
  localparam int AW = 13;
  localparam int DW = 24;

  typedef struct packed {
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } txn_t;

  typedef struct packed {
    logic [NW-1:0][DW-1:0] words;
    logic [NW-1:0][3:0]    stall;
    logic                  cat;
    logic [7:0]            done_dly;
    logic                  spurious;
    logic                  exp_cat;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst, start, px_valid, CatRecOut, done_flag;
  logic [DW-1:0] px_data;
  logic [DW-1:0] PRDATA = '0;
  logic          px_ready, PSEL, PENABLE, PWRITE, busy, result_valid, cat_result, err;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;

  apb_image_loader #(.ITERATION(NW)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .px_valid     (px_valid),
    .px_data      (px_data),
    .px_ready     (px_ready),
    .PSEL         (PSEL),
    .PENABLE      (PENABLE),
    .PWRITE       (PWRITE),
    .PADDR        (PADDR),
    .PWDATA       (PWDATA),
    .PRDATA       (PRDATA),
    .CatRecOut    (CatRecOut),
    .done_flag    (done_flag),
    .busy         (busy),
    .result_valid (result_valid),
    .cat_result   (cat_result),
    .err          (err)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int rv_count = 0;
  int s_count = 0;
  int proto_err = 0;
  int corrupt_addr = 0;
  logic err_exp = 1'b0;
  txn_t log_q[$];
  txn_t exp_q[$];
  logic [DW-1:0] mem [16];
  logic          prev_psel = 1'b0, prev_pen = 1'b0, prev_wr = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  logic [DW-1:0] prev_data = '0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endfunction

  function automatic logic [63:0] outs();
    return {19'd0, px_ready, PSEL, PENABLE, PWRITE, busy, result_valid, cat_result, err,
            PADDR, PWDATA};
  endfunction

  // Bus monitor, protocol watcher and a memory-backed slave for readback.
  always @(negedge clk) begin
    if (result_valid) rv_count <= rv_count + 1;
    if (PSEL && PENABLE) begin
      log_q.push_back('{w: PWRITE, a: PADDR, d: (PWRITE ? PWDATA : '0)});
      if (PWRITE) mem[PADDR[3:0]] <= PWDATA;
      if (PWRITE && PADDR == '0 && PWDATA == DW'(1)) s_count <= s_count + 1;
      if (!(prev_psel && !prev_pen) || PADDR !== prev_addr || PWDATA !== prev_data ||
          PWRITE !== prev_wr)
        proto_err <= proto_err + 1;
    end
    if (PENABLE && !PSEL) proto_err <= proto_err + 1;
    if (px_ready && PSEL) proto_err <= proto_err + 1;
    if (PSEL && !PWRITE)
      PRDATA <= (int'(PADDR) == corrupt_addr) ? 24'hFFFFFF : mem[PADDR[3:0]];
    else
      PRDATA <= '0;
    prev_psel <= PSEL;
    prev_pen  <= PENABLE;
    prev_wr   <= PWRITE;
    prev_addr <= PADDR;
    prev_data <= PWDATA;
  end

  // Reference: words to 1..N (each read back when enabled), then start=1 and start=0.
  function automatic void build_exp(input vec_t v);
    exp_q.delete();
    for (int i = 0; i < NW; i++) begin
      exp_q.push_back('{w: 1'b1, a: AW'(i + 1), d: v.words[i]});
`ifdef READBACK_VERIFY_EN
      exp_q.push_back('{w: 1'b0, a: AW'(i + 1), d: '0});
`endif
    end
    exp_q.push_back('{w: 1'b1, a: '0, d: DW'(1)});
    exp_q.push_back('{w: 1'b1, a: '0, d: '0});
  endfunction

  task automatic run_load(input vec_t v);
    int base = log_q.size();
    int rv0  = rv_count;
    int s0   = s_count;
    int pe0  = proto_err;
    build_exp(v);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    fork
      begin
        for (int i = 0; i < NW; i++) begin
          int t = 0;
          px_valid = 1'b0;
          repeat (int'(v.stall[i])) @(negedge clk);
          px_valid = 1'b1;
          px_data  = v.words[i];
          while (!px_ready && t < 200) begin @(negedge clk); t++; end
          chk("px_ready_timeout", 64'(t >= 200), 64'd0);
          @(negedge clk);
        end
        px_valid = 1'b0;
        px_data  = $urandom;
      end
      begin
        int t = 0;
        if (v.spurious) begin
          repeat (3) @(negedge clk);
          done_flag = 1'b1; CatRecOut = ~v.cat; start = 1'b1;
          @(negedge clk); start = 1'b0;
          @(negedge clk); done_flag = 1'b0;
        end
        while (s_count == s0 && t < 400) begin @(negedge clk); t++; end
        chk("start_write_timeout", 64'(t >= 400), 64'd0);
        if (t < 400) begin
          repeat (int'(v.done_dly)) @(negedge clk);
          done_flag = 1'b1; CatRecOut = v.cat;
          t = 0;
          while (!PSEL && t < 50) begin @(negedge clk); t++; end
          done_flag = 1'b0; CatRecOut = ~v.cat;
        end
      end
      begin
        int t = 0;
        while (rv_count == rv0 && t < 600) begin @(negedge clk); t++; end
        chk("result_valid_timeout", 64'(t >= 600), 64'd0);
      end
    join
    repeat (4) @(negedge clk);
    chk("txn_count", 64'(log_q.size() - base), 64'(exp_q.size()));
    for (int k = 0; k < exp_q.size(); k++) begin
      txn_t got = (base + k < log_q.size()) ? log_q[base + k] : '1;
      chk("txn", 64'(got), 64'(exp_q[k]));
    end
    chk("result_valid_pulses", 64'(rv_count - rv0), 64'd1);
    chk("cat_result", 64'(cat_result), 64'(v.exp_cat));
    chk("busy_after", 64'(busy), 64'd0);
    chk("err", 64'(err), 64'(err_exp));
    chk("protocol", 64'(proto_err - pe0), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  vec_t vecs[3];

  initial begin
    vecs[0] = '{words: {24'h0C0B0A, 24'h090807, 24'h060504, 24'h030201}, stall: 16'h0000,
                cat: 1'b1, done_dly: 8'd10, spurious: 1'b0, exp_cat: 1'b1};
    vecs[1] = '{words: {24'h444444, 24'h333333, 24'h222222, 24'h111111}, stall: 16'h0700,
                cat: 1'b0, done_dly: 8'd3, spurious: 1'b0, exp_cat: 1'b0};
    vecs[2] = '{words: {24'hABCDEF, 24'h123456, 24'hFEDCBA, 24'h654321}, stall: 16'h0000,
                cat: 1'b1, done_dly: 8'd5, spurious: 1'b1, exp_cat: 1'b1};

    rst = 1'b0; start = 1'b0; px_valid = 1'b0; px_data = '0;
    CatRecOut = 1'b0; done_flag = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", outs(), 64'd0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 3; i++) run_load(vecs[i]);

    for (int r = 0; r < 6; r++) begin
      vec_t v;
      for (int i = 0; i < NW; i++) begin
        v.words[i] = DW'($urandom);
        v.stall[i] = 4'($urandom_range(0, 3));
      end
      v.cat      = 1'($urandom_range(0, 1));
      v.done_dly = 8'($urandom_range(1, 12));
      v.spurious = 1'($urandom_range(0, 1));
      v.exp_cat  = v.cat;
      run_load(v);
    end

    // Reset during the ACCESS of word 2, then a fresh load from address 1.
    begin
      int t = 0;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0; px_valid = 1'b1; px_data = 24'hA5A5A5;
      while (!(PSEL && PENABLE && PWRITE && PADDR == AW'(2)) && t < 100) begin
        @(negedge clk); t++;
      end
      chk("midload_wait_timeout", 64'(t >= 100), 64'd0);
      rst = 1'b0; px_valid = 1'b0;
      err_exp = 1'b0;
      @(negedge clk);
      chk("midload_reset_outputs", outs(), 64'd0);
      rst = 1'b1;
      @(negedge clk);
      run_load(vecs[1]);
    end

`ifdef READBACK_VERIFY_EN
    corrupt_addr = 3;
    err_exp = 1'b1;
    run_load(vecs[0]);
    corrupt_addr = 0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
